// File: rtl/dmi_req_arbiter.sv
// Round-robin arbiter sharing one TCK-domain DMI channel among NumReq requesters, one transaction in flight.
// Optional grant locking for atomic sequences is enabled with `define DMI_ARB_LOCK_EN.
// Packing: request = {addr[6:0], op[1:0], data[31:0]}, response = {data[31:0], resp[1:0]}.
module dmi_req_arbiter #(
    parameter int  NumReq = 2,
    localparam int IdxW   = $clog2(NumReq),
    localparam int ReqW   = 41,
    localparam int RespW  = 34
) (
    input  logic                     tck_i,
    input  logic                     trst_ni,
    input  logic                     clear_i,
    input  logic [NumReq-1:0]        req_valid_i,
    input  logic [NumReq*ReqW-1:0]   req_i,
    output logic [NumReq-1:0]        req_ready_o,
    output logic [NumReq-1:0]        resp_valid_o,
    output logic [RespW-1:0]         resp_o,
    input  logic [NumReq-1:0]        resp_ready_i,
    input  logic [NumReq-1:0]        lock_i,
    output logic                     dmi_req_valid_o,
    output logic [ReqW-1:0]          dmi_req_o,
    input  logic                     dmi_req_ready_i,
    input  logic                     dmi_resp_valid_i,
    input  logic [RespW-1:0]         dmi_resp_i,
    output logic                     dmi_resp_ready_o,
    output logic                     busy_o,
    output logic [IdxW-1:0]          grant_o
);

`ifdef DMI_ARB_LOCK_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e            r_state;
    logic [IdxW-1:0]   r_rr;
    logic [IdxW-1:0]   r_grant;
    logic              r_lock;

    logic              w_can_win;
    logic [IdxW-1:0]   w_winner;
    logic              w_resp_hs;

    // First valid requester after the last served one, wrapping modulo NumReq.
    function automatic logic [IdxW-1:0] f_pick(input logic [NumReq-1:0] valid,
                                               input logic [IdxW-1:0]   last);
        logic [IdxW-1:0]   pick;
        logic [NumReq-1:0] shifted;
        logic              found;
        int                idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= NumReq; i++) begin
            idx     = (int'(last) + i) % NumReq;
            shifted = valid >> idx;
            if (!found && shifted[0]) begin
                pick  = IdxW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        w_can_win = 1'b0;
        w_winner  = r_grant;
        if (r_lock) begin
            w_can_win = req_valid_i[r_grant];
        end else begin
            w_can_win = |req_valid_i;
            w_winner  = f_pick(req_valid_i, r_rr);
        end
    end

    assign w_resp_hs = dmi_resp_valid_i && resp_ready_i[r_grant];

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_state <= S_IDLE;
            r_rr    <= IdxW'(NumReq - 1);
            r_grant <= '0;
            r_lock  <= 1'b0;
        end else if (clear_i) begin
            r_state <= S_IDLE;
            r_rr    <= IdxW'(NumReq - 1);
            r_lock  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_can_win) begin
                        r_grant <= w_winner;
                        r_state <= S_FWD;
                    end
                end
                S_FWD: begin
                    if (dmi_req_ready_i) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_resp_hs) begin
                        r_rr    <= r_grant;
                        r_lock  <= LockEn & lock_i[r_grant];
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Handshakes are suppressed during clear so an abandoned transaction never completes upstream.
    always_comb begin
        req_ready_o      = '0;
        resp_valid_o     = '0;
        dmi_resp_ready_o = 1'b1;
        if (!clear_i) begin
            case (r_state)
                S_FWD: begin
                    req_ready_o[r_grant] = dmi_req_ready_i;
                    dmi_resp_ready_o     = 1'b0;
                end
                S_WAIT: begin
                    resp_valid_o[r_grant] = dmi_resp_valid_i;
                    dmi_resp_ready_o      = resp_ready_i[r_grant];
                end
                default: dmi_resp_ready_o = 1'b1;
            endcase
        end
    end

    assign dmi_req_valid_o = (r_state == S_FWD) && !clear_i;
    assign dmi_req_o       = req_i[int'(r_grant)*ReqW +: ReqW];
    assign resp_o          = dmi_resp_i;
    assign busy_o          = (r_state != S_IDLE);
    assign grant_o         = r_grant;

`ifndef SYNTHESIS
    a_hold_valid: assert property (@(posedge tck_i) disable iff (!trst_ni)
        (r_state == S_FWD && !clear_i) |-> req_valid_i[r_grant]);
`endif

endmodule

// File: tb/tb_dmi_req_arbiter.sv
// Directed + randomized bench for dmi_req_arbiter (NumReq=2) against a transaction-level arbitration model.
module tb_dmi_req_arbiter;
    logic          tck_i = 1'b0;
    logic          trst_ni;
    logic          clear_i;
    logic [1:0]    req_valid_i;
    logic [81:0]   req_i;
    logic [1:0]    req_ready_o;
    logic [1:0]    resp_valid_o;
    logic [33:0]   resp_o;
    logic [1:0]    resp_ready_i;
    logic [1:0]    lock_i;
    logic          dmi_req_valid_o;
    logic [40:0]   dmi_req_o;
    logic          dmi_req_ready_i;
    logic          dmi_resp_valid_i;
    logic [33:0]   dmi_resp_i;
    logic          dmi_resp_ready_o;
    logic          busy_o;
    logic          grant_o;

    logic [40:0]   reqs [2];
    int            checks = 0;
    int            errors = 0;

    // Model state: last served requester, lock flag and its holder.
    int            m_last   = 1;
    bit            m_lock   = 1'b0;
    int            m_holder = 0;

    always #5 tck_i = ~tck_i;
    always_comb req_i = {reqs[1], reqs[0]};

    dmi_req_arbiter #(.NumReq(2)) dut (
        .tck_i(tck_i), .trst_ni(trst_ni), .clear_i(clear_i),
        .req_valid_i(req_valid_i), .req_i(req_i), .req_ready_o(req_ready_o),
        .resp_valid_o(resp_valid_o), .resp_o(resp_o), .resp_ready_i(resp_ready_i),
        .lock_i(lock_i), .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_o(dmi_req_o),
        .dmi_req_ready_i(dmi_req_ready_i), .dmi_resp_valid_i(dmi_resp_valid_i),
        .dmi_resp_i(dmi_resp_i), .dmi_resp_ready_o(dmi_resp_ready_o),
        .busy_o(busy_o), .grant_o(grant_o)
    );

    task automatic tick();
        @(posedge tck_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [40:0] rnd_req();
        return {7'($urandom), 2'($urandom), 32'($urandom)};
    endfunction

    function automatic int m_pick(input logic [1:0] mask);
        logic [1:0] sh;
        if (m_lock) return m_holder;
        for (int k = 1; k <= 2; k++) begin
            sh = mask >> ((m_last + k) % 2);
            if (sh[0]) return (m_last + k) % 2;
        end
        return 0;
    endfunction

    task automatic model_clear();
        m_last = 1;
        m_lock = 1'b0;
    endtask

    // One complete transaction: rdly cycles of downstream request stall, pdly cycles of response stall.
    task automatic txn(input logic [1:0] mask, input logic [1:0] lk, input int rdly,
                       input int pdly, input logic [33:0] rsp, output int g);
        logic [1:0] onehot;
        int         w;
        w                = m_pick(mask);
        onehot           = 2'b01 << w;
        req_valid_i      = mask;
        lock_i           = lk;
        resp_ready_i     = 2'b11;
        dmi_req_ready_i  = 1'b0;
        dmi_resp_valid_i = 1'b0;
        tick();
        g = int'(grant_o);
        chk("grant", 64'(grant_o), 64'(w));
        chk("fwd_busy", 64'(busy_o), 64'(1));
        chk("fwd_req_vld", 64'(dmi_req_valid_o), 64'(1));
        chk("fwd_req_data", 64'(dmi_req_o), 64'(reqs[w]));
        dmi_resp_valid_i = 1'b1;
        dmi_resp_i       = ~rsp;
        #1;
        chk("fwd_resp_rdy", 64'(dmi_resp_ready_o), 64'(0));
        chk("fwd_resp_vld", 64'(resp_valid_o), 64'(0));
        for (int i = 0; i < rdly; i++) begin
            chk("bp_req_rdy", 64'(req_ready_o), 64'(0));
            tick();
            chk("bp_req_vld", 64'(dmi_req_valid_o), 64'(1));
            chk("bp_req_stable", 64'(dmi_req_o), 64'(reqs[w]));
        end
        dmi_req_ready_i = 1'b1;
        #1;
        chk("req_rdy", 64'(req_ready_o), 64'(onehot));
        tick();
        dmi_req_ready_i = 1'b0;
        dmi_resp_i      = rsp;
        resp_ready_i    = ~onehot;
        for (int i = 0; i < pdly; i++) begin
            #1;
            chk("bp_resp_rdy", 64'(dmi_resp_ready_o), 64'(0));
            chk("bp_busy", 64'(busy_o), 64'(1));
            chk("bp_resp_vld", 64'(resp_valid_o), 64'(onehot));
            tick();
        end
        resp_ready_i = 2'b11;
        #1;
        chk("resp_vld", 64'(resp_valid_o), 64'(onehot));
        chk("resp_data", 64'(resp_o), 64'(rsp));
        chk("resp_rdy", 64'(dmi_resp_ready_o), 64'(1));
        tick();
        dmi_resp_valid_i = 1'b0;
        req_valid_i      = 2'b00;
        m_last           = w;
        m_holder         = w;
`ifdef DMI_ARB_LOCK_EN
        m_lock = lk[w];
`else
        m_lock = 1'b0;
`endif
        reqs[w] = rnd_req();
        #1;
        chk("idle_busy", 64'(busy_o), 64'(0));
    endtask

    initial begin
        int         g;
        int         exp_lock [3];
        logic [1:0] mask;
        trst_ni          = 1'b0;
        clear_i          = 1'b0;
        req_valid_i      = 2'b00;
        resp_ready_i     = 2'b11;
        lock_i           = 2'b00;
        dmi_req_ready_i  = 1'b0;
        dmi_resp_valid_i = 1'b0;
        dmi_resp_i       = '0;
        reqs[0]          = rnd_req();
        reqs[1]          = rnd_req();
        repeat (3) tick();
        trst_ni = 1'b1;
        tick();
        chk("rst_req_vld", 64'(dmi_req_valid_o), 64'(0));
        chk("rst_resp_rdy", 64'(dmi_resp_ready_o), 64'(1));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_grant", 64'(grant_o), 64'(0));
        chk("rst_req_rdy", 64'(req_ready_o), 64'(0));
        chk("rst_resp_vld", 64'(resp_valid_o), 64'(0));

        // Single read from requester 0.
        reqs[0] = {7'h11, 2'd1, 32'h0};
        txn(2'b01, 2'b00, 0, 0, {32'h1234_5678, 2'b00}, g);

        // Fairness from a cleared round-robin pointer.
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        model_clear();
        for (int i = 0; i < 6; i++) begin
            txn(2'b11, 2'b00, 0, 0, 34'($urandom), g);
            chk("fair_seq", 64'(g), 64'(i % 2));
        end

        // Clear while requester 1 waits for its response.
        req_valid_i = 2'b10;
        tick();
        chk("clr_grant", 64'(grant_o), 64'(1));
        dmi_req_ready_i = 1'b1;
        tick();
        req_valid_i      = 2'b00;
        dmi_req_ready_i  = 1'b0;
        clear_i          = 1'b1;
        dmi_resp_valid_i = 1'b1;
        dmi_resp_i       = 34'h2_AAAA_5555;
        #1;
        chk("clr_resp_vld", 64'(resp_valid_o), 64'(0));
        chk("clr_req_rdy", 64'(req_ready_o), 64'(0));
        tick();
        clear_i = 1'b0;
        model_clear();
        #1;
        chk("clr_idle_busy", 64'(busy_o), 64'(0));
        chk("clr_late_rdy", 64'(dmi_resp_ready_o), 64'(1));
        chk("clr_late_vld", 64'(resp_valid_o), 64'(0));
        tick();
        dmi_resp_valid_i = 1'b0;
        #1;
        chk("clr_stay_idle", 64'(busy_o), 64'(0));

        // Backpressure on both sides.
        txn(2'b01, 2'b00, 5, 3, 34'($urandom), g);

        // Lock sequence: requester 0 asks to keep the grant for one follow-up.
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        model_clear();
`ifdef DMI_ARB_LOCK_EN
        exp_lock = '{0, 0, 1};
`else
        exp_lock = '{0, 1, 0};
`endif
        txn(2'b11, 2'b01, 0, 0, 34'($urandom), g);
        chk("lock_g0", 64'(g), 64'(exp_lock[0]));
        txn(2'b11, 2'b00, 0, 0, 34'($urandom), g);
        chk("lock_g1", 64'(g), 64'(exp_lock[1]));
        txn(2'b11, 2'b00, 0, 0, 34'($urandom), g);
        chk("lock_g2", 64'(g), 64'(exp_lock[2]));

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            mask = 2'($urandom_range(1, 3));
            if (m_lock) mask[m_holder] = 1'b1;
            txn(mask, 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 34'($urandom), g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
